// File: rtl/iq_decimator.sv
// iq_decimator: keeps one I/Q sample per DECIM-sample group at a selectable
// phase and buffers the kept samples in a first-word-fall-through FIFO.
// The input is never stalled; a kept sample that finds the FIFO full with no
// simultaneous pop is dropped and the sticky overflow flag is raised.
// Optional feature macro: IQ_DECIM_AVG_EN. When defined, each kept value is
// the floor-divided mean of its window instead of the single picked sample.
module iq_decimator #(
    parameter int DATA_W     = 12,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data_i,
    input  logic [DATA_W-1:0]             in_data_q,
    output logic                          in_ready,
    input  logic [$clog2(DECIM)-1:0]      phase,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data_i,
    output logic [DATA_W-1:0]             out_data_q,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(DECIM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [2*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [2*DATA_W-1:0] head;

    logic                keep, pop, push;
    logic [DATA_W-1:0]   wr_data_i, wr_data_q;

`ifdef IQ_DECIM_AVG_EN
    localparam int ACC_W = DATA_W + CNT_W;

    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] sum_i, sum_q;

    // Running window sums; the kept value is the sum shifted right by
    // log2(DECIM), which is just the upper DATA_W bits of the sum.
    always_comb begin
        sum_i     = acc_i_q + {{CNT_W{in_data_i[DATA_W-1]}}, in_data_i};
        sum_q     = acc_q_q + {{CNT_W{in_data_q[DATA_W-1]}}, in_data_q};
        wr_data_i = sum_i[ACC_W-1:CNT_W];
        wr_data_q = sum_q[ACC_W-1:CNT_W];
        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        if (in_valid) begin
            acc_i_d = keep ? '0 : sum_i;
            acc_q_d = keep ? '0 : sum_q;
        end
    end

    // Accumulator registers; cleared at every keep so windows start fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end
`else
    // Pick mode: the kept sample goes into the FIFO unchanged.
    always_comb begin
        wr_data_i = in_data_i;
        wr_data_q = in_data_q;
    end
`endif

    // Group counter, keep decision and FIFO bookkeeping.
    always_comb begin
        keep       = in_valid && (cnt_q == phase);
        pop        = (level_q != '0) && out_ready;
        // A full FIFO still accepts a push when the head leaves in the same edge.
        push       = keep && ((level_q != FULL) || pop);
        cnt_d      = in_valid ? cnt_q + CNT_W'(1) : cnt_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop)
            level_d = level_q + LVL_W'(1);
        else if (pop && !push)
            level_d = level_q - LVL_W'(1);
        overflow_d = overflow_q | (keep && (level_q == FULL) && !pop);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; not reset, the level count masks stale entries.
    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo_mem[wr_ptr_q] <= {wr_data_i, wr_data_q};
    end

    // First-word-fall-through output, forced to zero while empty.
    always_comb begin
        head       = fifo_mem[rd_ptr_q];
        in_ready   = 1'b1;
        out_valid  = (level_q != '0);
        out_data_i = out_valid ? head[2*DATA_W-1:DATA_W] : '0;
        out_data_q = out_valid ? head[DATA_W-1:0]        : '0;
        level      = level_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_iq_decimator.sv
// tb_iq_decimator: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model of the decimator.
module tb_iq_decimator;

    localparam int DATA_W = 12;
    localparam int DECIM  = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 2;
    localparam int ACC_W  = DATA_W + CNT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data_i = '0, in_data_q = '0;
    logic              in_ready;
    logic [CNT_W-1:0]  phase = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data_i, out_data_q;
    logic              out_ready = 1'b0;
    logic [3:0]        level;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [DATA_W-1:0] exp_i[$], exp_q[$];
    int                win_i[$], win_q[$];
    int                m_accepts = 0;
    bit                m_ovf = 0;

    iq_decimator #(.DATA_W(DATA_W), .DECIM(DECIM), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data_i(in_data_i),
        .in_data_q(in_data_q), .in_ready(in_ready), .phase(phase),
        .out_valid(out_valid), .out_data_i(out_data_i), .out_data_q(out_data_q),
        .out_ready(out_ready), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Window value: sum wrapped to the accumulator width, floor-divided by DECIM.
    function automatic logic [DATA_W-1:0] avg_of(input int w[$], input int cur);
        int s;
        s = cur;
        foreach (w[k]) s += w[k];
        s = (s <<< (32 - ACC_W)) >>> (32 - ACC_W);
        s = s >>> CNT_W;
        return s[DATA_W-1:0];
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit keep, pop;
        int pre;
        logic [DATA_W-1:0] vi, vq;
        if (rst) begin
            exp_i.delete(); exp_q.delete(); win_i.delete(); win_q.delete();
            m_accepts = 0; m_ovf = 0;
            return;
        end
        pre  = exp_i.size();
        pop  = (pre != 0) && out_ready;
        keep = in_valid && ((m_accepts % DECIM) == int'(phase));
`ifdef IQ_DECIM_AVG_EN
        vi = avg_of(win_i, int'($signed(in_data_i)));
        vq = avg_of(win_q, int'($signed(in_data_q)));
        if (in_valid) begin
            if (keep) begin
                win_i.delete(); win_q.delete();
            end else begin
                win_i.push_back(int'($signed(in_data_i)));
                win_q.push_back(int'($signed(in_data_q)));
            end
        end
`else
        vi = in_data_i;
        vq = in_data_q;
`endif
        if (in_valid) m_accepts++;
        if (pop) begin
            void'(exp_i.pop_front());
            void'(exp_q.pop_front());
        end
        if (keep) begin
            if (pre < DEPTH || pop) begin
                exp_i.push_back(vi);
                exp_q.push_back(vq);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_i.size() != 0));
        chk("level", 32'(level), 32'(exp_i.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("out_data_i", 32'(out_data_i), (exp_i.size() != 0) ? 32'(exp_i[0]) : 32'd0);
        chk("out_data_q", 32'(out_data_q), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
        chk("in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic cyc(input bit v, input int di, input int dq, input bit rdy);
        in_valid  = v;
        in_data_i = di[DATA_W-1:0];
        in_data_q = dq[DATA_W-1:0];
        out_ready = rdy;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        do_reset();

        // 1: phase 0 ramp, free-flowing output
        phase = 2'd0;
        for (int k = 0; k < 16; k++) cyc(1, k, k + 1000, 1);

        // 2: phase 3 ramp, then switch 3->1 while cnt==2
        do_reset();
        phase = 2'd3;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) phase = 2'd1;
            cyc(1, k, k, 1);
`ifndef IQ_DECIM_AVG_EN
            if (k == 5) chk("phase_switch_first", 32'(out_data_i), 32'd5);
            if (k == 9) chk("phase_switch_second", 32'(out_data_i), 32'd9);
`endif
        end

        // 3: overflow with stalled consumer, then drain
        do_reset();
        phase = 2'd0;
        for (int k = 0; k < 36; k++) cyc(1, k, -k, 0);
        chk("ovf_level_full", 32'(level), 32'd8);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1);
        chk("ovf_after_drain", 32'(overflow), 32'd1);

        // 4: full FIFO, keep coincides with a pop
        do_reset();
        for (int k = 0; k < 32; k++) cyc(1, k, k, 0);
        cyc(1, 32, 32, 1);
        chk("full_pop_push_level", 32'(level), 32'd8);
        chk("full_pop_push_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1);

        // 5: reset mid-stream with level 3
        do_reset();
        for (int k = 0; k < 12; k++) cyc(1, k, k, 0);
        chk("pre_reset_level", 32'(level), 32'd3);
        do_reset();
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 100 + k, 200 + k, 1);
`ifndef IQ_DECIM_AVG_EN
            if (k == 0) chk("resume_first", 32'(out_data_i), 32'd100);
`endif
        end

`ifdef IQ_DECIM_AVG_EN
        // 6: averaging windows, including floor rounding of negatives
        do_reset();
        phase = 2'd3;
        for (int k = 0; k < 8; k++) begin
            cyc(1, k, k, 1);
            if (k == 3) chk("avg_first", 32'(out_data_i), 32'd1);
            if (k == 7) chk("avg_second", 32'(out_data_i), 32'd5);
        end
        cyc(1, -1, 0, 1);
        cyc(1, -2, 0, 1);
        cyc(1, -1, 0, 1);
        cyc(1, -2, 0, 1);
        chk("avg_negative_floor", 32'(out_data_i), 32'hFFE);
`endif

        // random traffic with occasional phase changes and resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2) phase = CNT_W'($urandom_range(0, DECIM - 1));
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0, int'($urandom), int'($urandom),
                    (n % 600) < 300 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iq_decimator.md
Name: iq_decimator

Overview:
- Downstream of the complex FIR low-pass. Consumes its I/Q sample stream and keeps one of every DECIM samples at a selectable phase.
- Buffers kept samples in a small first-word-fall-through (FWFT) FIFO and presents them to the next stage over a valid/ready handshake.
- The FIR has no backpressure, so this block absorbs rate mismatch, drops samples on overflow, and flags the overflow.

Parameters:
- DATA_W, 12, width of each signed I and Q sample.
- DECIM, 4, decimation factor; power of 2, range 2..64.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input sample present this cycle
- in_data_i  in  DATA_W  signed I sample
- in_data_q  in  DATA_W  signed Q sample
- in_ready  out  1  tied to 1; input is never stalled
- phase  in  log2(DECIM)  index of the kept sample within each DECIM group
- out_valid  out  1  FIFO non-empty
- out_data_i  out  DATA_W  signed I at FIFO head
- out_data_q  out  DATA_W  signed Q at FIFO head
- out_ready  in  1  consumer accepts the head sample
- level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a kept sample was dropped

Behaviour:
- Reset values: cnt=0, FIFO empty, wr_ptr=rd_ptr=0, out_valid=0, out_data_i/q=0, level=0, overflow=0, accumulator=0. Reset wins over any simultaneous event.
- Input accept: every cycle with in_valid=1. cnt increments modulo DECIM on each accept and holds when in_valid=0.
- Keep: an accepted sample is kept when cnt==phase, using the pre-increment cnt.
- phase is not registered. A change takes effect at the next compare. cnt is not reset by a phase change, so the gap between kept samples may be shorter or longer than DECIM once.
- Push: a kept sample is written into the FIFO in the same clock edge.
- Latency: from the accepting edge to out_valid=1 with that sample at the head is 1 cycle when the FIFO is empty.
- FWFT output: out_valid = (level != 0). out_data_i/q = mem[rd_ptr] when out_valid=1, else 0. The memory itself is not reset.
- Pop: occurs when out_valid && out_ready. rd_ptr advances.
- out_ready while out_valid=0 is ignored.
- Pointers wrap modulo FIFO_DEPTH. level ranges 0..FIFO_DEPTH.
- Push with level<FIFO_DEPTH: stored, level+1, or level unchanged with a simultaneous pop.
- Push with level==FIFO_DEPTH and a simultaneous pop: stored, level stays FIFO_DEPTH, no overflow.
- Push with level==FIFO_DEPTH and no pop: sample discarded, FIFO unchanged, overflow<=1. overflow clears only on rst.
- Pop with level==0: impossible by construction; no state change.
- Reset mid-operation: all buffered samples are lost. The group count restarts, so the first keep after reset is the sample with index==phase.

Optional Feature:
- Macro: IQ_DECIM_AVG_EN.
- Undefined (default behaviour):
  - The pushed value is the accepted sample at cnt==phase (pick mode).
  - No accumulator is instantiated.
- Defined (average mode):
  - Each accepted sample is added to signed accumulators acc_i/acc_q of width DATA_W+log2(DECIM).
  - At a keep, the pushed value is (acc + current sample) >>> log2(DECIM): arithmetic shift, floor rounding, truncated to DATA_W. The accumulator is then cleared in the same edge.
  - The first window after reset or a phase change may contain fewer than DECIM samples; it is still divided by DECIM.
  - All FIFO and overflow behaviour is unchanged.

Test Plan:
1. DECIM=4, phase=0, in_valid=1, I=Q=ramp 0,1,2,..., out_ready=1 -> outputs 0,4,8,12; out_valid pulses one cycle after each keep; level never exceeds 1.
2. Same stimulus with phase=3 -> outputs 3,7,11. Switch phase 3->1 while cnt=2: next kept sample is index 5, i.e. value 5, then 9.
3. out_ready=0, phase=0, 9 keeps -> level=8 after the 8th keep; 9th sample (value 32) dropped; overflow=1; then draining with out_ready=1 yields 0,4,...,28.
4. FIFO full, keep coincides with out_ready=1 -> pop 0 and push 32 in the same edge; level stays 8; overflow stays 0.
5. rst asserted for 1 cycle mid-stream with level=3 -> out_valid=0, level=0, out_data=0, overflow=0 next cycle; ramp resuming at 100 with phase=0 yields 100 first.
6. IQ_DECIM_AVG_EN, DECIM=4, phase=3:
   - ramp 0..7 -> outputs 1 (6>>>2) and 5 (22>>>2).
   - I = -1,-2,-1,-2 -> -2 (floor of -1.5).
